// File: rtl/wb_retire_unit.sv
`default_nettype none
// ============================================================================
// Module   : wb_retire_unit
// Brief    : WB-stage retire unit. Commits GPR/CSR writes, counts retired
//            instructions and sequences trap entry (mepc, mcause, [mtval],
//            fetch redirect). Optional macro: RETIRE_MTVAL_EN.
// Revision : 1.0 - initial release
// ============================================================================
module wb_retire_unit #(
    parameter logic [11:0] MEPC_ADDR   = 12'h341,
    parameter logic [11:0] MCAUSE_ADDR = 12'h342,
`ifdef RETIRE_MTVAL_EN
    parameter logic [11:0] MTVAL_ADDR  = 12'h343,
`endif
    parameter int          INSTRET_W   = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wb_q_valid,
    input  logic [4:0]           wb_q_rd_addr,
    input  logic [31:0]          wb_q_rd_wdata,
    input  logic                 wb_q_is_rd_write,
    input  logic [11:0]          wb_q_csr_addr,
    input  logic [31:0]          wb_q_csr_wdata,
    input  logic                 wb_q_is_csr_write,
    input  logic                 wb_q_trap_valid,
    input  logic [31:0]          wb_q_trap_mcause,
    input  logic [31:0]          wb_q_trap_pc,
`ifdef RETIRE_MTVAL_EN
    input  logic [31:0]          wb_q_trap_mtval,
`endif
    input  logic [31:0]          mtvec_i,
    output logic                 rf_we_o,
    output logic [4:0]           rf_waddr_o,
    output logic [31:0]          rf_wdata_o,
    output logic                 csr_we_o,
    output logic [11:0]          csr_waddr_o,
    output logic [31:0]          csr_wdata_o,
    output logic                 mem_wb_flush_o,
    output logic                 mem_wb_stall_o,
    output logic                 redirect_valid_o,
    output logic [31:0]          redirect_pc_o,
    output logic [INSTRET_W-1:0] instret_o
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_T_EPC   = 3'd1;
    localparam logic [2:0] S_T_CAUSE = 3'd2;
`ifdef RETIRE_MTVAL_EN
    localparam logic [2:0] S_T_TVAL  = 3'd3;
`endif
    localparam logic [2:0] S_T_VEC   = 3'd4;

    logic [2:0]           state_q,   state_d;
    logic [31:0]          pc_q,      pc_d;
    logic [31:0]          cause_q,   cause_d;
    logic [INSTRET_W-1:0] instret_q, instret_d;
`ifdef RETIRE_MTVAL_EN
    logic [31:0]          tval_q,    tval_d;
`endif
    logic [31:0]          vec_base;
    logic [31:0]          vec_target;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            cause_q   <= '0;
            instret_q <= '0;
`ifdef RETIRE_MTVAL_EN
            tval_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cause_q   <= cause_d;
            instret_q <= instret_d;
`ifdef RETIRE_MTVAL_EN
            tval_q    <= tval_d;
`endif
        end
    end

    // Next state and latched trap context
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cause_d   = cause_q;
        instret_d = instret_q;
`ifdef RETIRE_MTVAL_EN
        tval_d    = tval_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (wb_q_valid) begin
                    if (wb_q_trap_valid) begin
                        pc_d    = wb_q_trap_pc;
                        cause_d = wb_q_trap_mcause;
`ifdef RETIRE_MTVAL_EN
                        tval_d  = wb_q_trap_mtval;
`endif
                        state_d = S_T_EPC;
                    end else begin
                        instret_d = instret_q + 1'b1;
                    end
                end
            end
            S_T_EPC:   state_d = S_T_CAUSE;
`ifdef RETIRE_MTVAL_EN
            S_T_CAUSE: state_d = S_T_TVAL;
            S_T_TVAL:  state_d = S_T_VEC;
`else
            S_T_CAUSE: state_d = S_T_VEC;
`endif
            S_T_VEC:   state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Vectored mode only applies to interrupts; the add wraps at 32 bits.
    always_comb begin
        vec_base   = {mtvec_i[31:2], 2'b00};
        vec_target = vec_base;
        if (mtvec_i[1:0] == 2'b01 && cause_q[31]) begin
            vec_target = vec_base + {cause_q[29:0], 2'b00};
        end
    end

    // Outputs; everything reads zero while reset is held
    always_comb begin
        rf_we_o          = 1'b0;
        rf_waddr_o       = '0;
        rf_wdata_o       = '0;
        csr_we_o         = 1'b0;
        csr_waddr_o      = '0;
        csr_wdata_o      = '0;
        mem_wb_flush_o   = 1'b0;
        mem_wb_stall_o   = 1'b0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = '0;
        if (!rst_i) begin
            if (state_q != S_IDLE) begin
                mem_wb_flush_o = 1'b1;
                mem_wb_stall_o = 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (wb_q_valid && wb_q_trap_valid) begin
                        mem_wb_flush_o = 1'b1;
                    end else if (wb_q_valid) begin
                        rf_we_o     = wb_q_is_rd_write && (wb_q_rd_addr != 5'd0);
                        rf_waddr_o  = wb_q_rd_addr;
                        rf_wdata_o  = wb_q_rd_wdata;
                        csr_we_o    = wb_q_is_csr_write;
                        csr_waddr_o = wb_q_csr_addr;
                        csr_wdata_o = wb_q_csr_wdata;
                    end
                end
                S_T_EPC: begin
                    csr_we_o    = 1'b1;
                    csr_waddr_o = MEPC_ADDR;
                    csr_wdata_o = pc_q;
                end
                S_T_CAUSE: begin
                    csr_we_o    = 1'b1;
                    csr_waddr_o = MCAUSE_ADDR;
                    csr_wdata_o = cause_q;
                end
`ifdef RETIRE_MTVAL_EN
                S_T_TVAL: begin
                    csr_we_o    = 1'b1;
                    csr_waddr_o = MTVAL_ADDR;
                    csr_wdata_o = tval_q;
                end
`endif
                S_T_VEC: begin
                    redirect_valid_o = 1'b1;
                    redirect_pc_o    = vec_target;
                end
                default: ;
            endcase
        end
    end

    assign instret_o = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_retire_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_retire_unit
// Brief    : Directed, table-driven self-checking bench for wb_retire_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_retire_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        wb_q_valid;
    logic [4:0]  wb_q_rd_addr;
    logic [31:0] wb_q_rd_wdata;
    logic        wb_q_is_rd_write;
    logic [11:0] wb_q_csr_addr;
    logic [31:0] wb_q_csr_wdata;
    logic        wb_q_is_csr_write;
    logic        wb_q_trap_valid;
    logic [31:0] wb_q_trap_mcause;
    logic [31:0] wb_q_trap_pc;
`ifdef RETIRE_MTVAL_EN
    logic [31:0] wb_q_trap_mtval;
`endif
    logic [31:0] mtvec_i;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        csr_we_o;
    logic [11:0] csr_waddr_o;
    logic [31:0] csr_wdata_o;
    logic        mem_wb_flush_o;
    logic        mem_wb_stall_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic [63:0] instret_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    wb_retire_unit dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .wb_q_valid        (wb_q_valid),
        .wb_q_rd_addr      (wb_q_rd_addr),
        .wb_q_rd_wdata     (wb_q_rd_wdata),
        .wb_q_is_rd_write  (wb_q_is_rd_write),
        .wb_q_csr_addr     (wb_q_csr_addr),
        .wb_q_csr_wdata    (wb_q_csr_wdata),
        .wb_q_is_csr_write (wb_q_is_csr_write),
        .wb_q_trap_valid   (wb_q_trap_valid),
        .wb_q_trap_mcause  (wb_q_trap_mcause),
        .wb_q_trap_pc      (wb_q_trap_pc),
`ifdef RETIRE_MTVAL_EN
        .wb_q_trap_mtval   (wb_q_trap_mtval),
`endif
        .mtvec_i           (mtvec_i),
        .rf_we_o           (rf_we_o),
        .rf_waddr_o        (rf_waddr_o),
        .rf_wdata_o        (rf_wdata_o),
        .csr_we_o          (csr_we_o),
        .csr_waddr_o       (csr_waddr_o),
        .csr_wdata_o       (csr_wdata_o),
        .mem_wb_flush_o    (mem_wb_flush_o),
        .mem_wb_stall_o    (mem_wb_stall_o),
        .redirect_valid_o  (redirect_valid_o),
        .redirect_pc_o     (redirect_pc_o),
        .instret_o         (instret_o)
    );

    typedef struct {
        logic        valid;
        logic [4:0]  rd;
        logic [31:0] rd_wdata;
        logic        rd_wr;
        logic [11:0] csr_addr;
        logic [31:0] csr_wdata;
        logic        csr_wr;
        logic        exp_rf_we;
        logic        exp_csr_we;
        logic [63:0] exp_instret;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wb_q_valid        = 1'b0;
        wb_q_rd_addr      = 5'd0;
        wb_q_rd_wdata     = 32'd0;
        wb_q_is_rd_write  = 1'b0;
        wb_q_csr_addr     = 12'd0;
        wb_q_csr_wdata    = 32'd0;
        wb_q_is_csr_write = 1'b0;
        wb_q_trap_valid   = 1'b0;
        wb_q_trap_mcause  = 32'd0;
        wb_q_trap_pc      = 32'd0;
`ifdef RETIRE_MTVAL_EN
        wb_q_trap_mtval   = 32'd0;
`endif
    endtask

    // Non-trapping junk applied during trap entry; it must be ignored.
    task automatic junk_inputs();
        wb_q_valid        = 1'b1;
        wb_q_trap_valid   = 1'b0;
        wb_q_rd_addr      = 5'd9;
        wb_q_rd_wdata     = 32'h1111_2222;
        wb_q_is_rd_write  = 1'b1;
        wb_q_csr_addr     = 12'h305;
        wb_q_csr_wdata    = 32'h3333_4444;
        wb_q_is_csr_write = 1'b1;
    endtask

    task automatic run_trap(input logic [31:0] pc, input logic [31:0] cause,
                            input logic [31:0] mtvec, input logic [31:0] exp_target,
                            input logic [63:0] exp_instret);
        @(negedge clk_i);
        idle_inputs();
        wb_q_valid       = 1'b1;
        wb_q_trap_valid  = 1'b1;
        wb_q_trap_pc     = pc;
        wb_q_trap_mcause = cause;
        wb_q_is_rd_write = 1'b1;
        wb_q_rd_addr     = 5'd7;
        wb_q_is_csr_write = 1'b1;
`ifdef RETIRE_MTVAL_EN
        wb_q_trap_mtval  = 32'hBAD0_0000;
`endif
        mtvec_i = mtvec;
        #1;
        check("detect_flush", 64'(mem_wb_flush_o), 64'd1);
        check("detect_stall", 64'(mem_wb_stall_o), 64'd0);
        check("detect_rf_we", 64'(rf_we_o), 64'd0);
        check("detect_csr_we", 64'(csr_we_o), 64'd0);
        @(negedge clk_i);
        junk_inputs();
        #1;
        check("epc_stall", 64'(mem_wb_stall_o), 64'd1);
        check("epc_flush", 64'(mem_wb_flush_o), 64'd1);
        check("epc_rf_we", 64'(rf_we_o), 64'd0);
        check("epc_csr_we", 64'(csr_we_o), 64'd1);
        check("epc_addr", 64'(csr_waddr_o), 64'h341);
        check("epc_data", 64'(csr_wdata_o), 64'(pc));
        @(negedge clk_i);
        #1;
        check("cause_stall", 64'(mem_wb_stall_o), 64'd1);
        check("cause_csr_we", 64'(csr_we_o), 64'd1);
        check("cause_addr", 64'(csr_waddr_o), 64'h342);
        check("cause_data", 64'(csr_wdata_o), 64'(cause));
        check("cause_redirect", 64'(redirect_valid_o), 64'd0);
`ifdef RETIRE_MTVAL_EN
        @(negedge clk_i);
        #1;
        check("tval_stall", 64'(mem_wb_stall_o), 64'd1);
        check("tval_addr", 64'(csr_waddr_o), 64'h343);
        check("tval_data", 64'(csr_wdata_o), 64'hBAD0_0000);
`endif
        @(negedge clk_i);
        #1;
        check("vec_stall", 64'(mem_wb_stall_o), 64'd1);
        check("vec_rf_we", 64'(rf_we_o), 64'd0);
        check("vec_csr_we", 64'(csr_we_o), 64'd0);
        check("vec_redirect", 64'(redirect_valid_o), 64'd1);
        check("vec_target", 64'(redirect_pc_o), 64'(exp_target));
        @(negedge clk_i);
        idle_inputs();
        #1;
        check("post_redirect", 64'(redirect_valid_o), 64'd0);
        check("post_stall", 64'(mem_wb_stall_o), 64'd0);
        check("post_instret", instret_o, exp_instret);
    endtask

    initial begin
        vecs[0] = '{1'b1, 5'd5,  32'hDEAD_BEEF, 1'b1, 12'h000, 32'h0,         1'b0, 1'b1, 1'b0, 64'd1};
        vecs[1] = '{1'b1, 5'd0,  32'h0000_00FF, 1'b1, 12'h000, 32'h0,         1'b0, 1'b0, 1'b0, 64'd2};
        vecs[2] = '{1'b0, 5'd7,  32'h0000_0077, 1'b1, 12'h340, 32'h55,        1'b1, 1'b0, 1'b0, 64'd2};
        vecs[3] = '{1'b1, 5'd3,  32'h0000_0003, 1'b0, 12'h300, 32'h0000_1888, 1'b1, 1'b0, 1'b1, 64'd3};
        vecs[4] = '{1'b1, 5'd31, 32'h1234_5678, 1'b1, 12'h7C0, 32'hA5A5_A5A5, 1'b1, 1'b1, 1'b1, 64'd4};

        // Reset with a live-looking retire on the inputs: outputs must stay 0
        rst_i   = 1'b1;
        mtvec_i = 32'h0;
        junk_inputs();
        repeat (2) @(negedge clk_i);
        #1;
        check("rst_rf_we", 64'(rf_we_o), 64'd0);
        check("rst_csr_we", 64'(csr_we_o), 64'd0);
        check("rst_redirect", 64'(redirect_valid_o), 64'd0);
        check("rst_instret", instret_o, 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        idle_inputs();

        foreach (vecs[i]) begin
            @(negedge clk_i);
            wb_q_valid        = vecs[i].valid;
            wb_q_rd_addr      = vecs[i].rd;
            wb_q_rd_wdata     = vecs[i].rd_wdata;
            wb_q_is_rd_write  = vecs[i].rd_wr;
            wb_q_csr_addr     = vecs[i].csr_addr;
            wb_q_csr_wdata    = vecs[i].csr_wdata;
            wb_q_is_csr_write = vecs[i].csr_wr;
            wb_q_trap_valid   = 1'b0;
            #1;
            check($sformatf("v%0d_rf_we", i), 64'(rf_we_o), 64'(vecs[i].exp_rf_we));
            check($sformatf("v%0d_csr_we", i), 64'(csr_we_o), 64'(vecs[i].exp_csr_we));
            check($sformatf("v%0d_flush", i), 64'(mem_wb_flush_o), 64'd0);
            check($sformatf("v%0d_stall", i), 64'(mem_wb_stall_o), 64'd0);
            if (vecs[i].exp_rf_we) begin
                check($sformatf("v%0d_rf_addr", i), 64'(rf_waddr_o), 64'(vecs[i].rd));
                check($sformatf("v%0d_rf_data", i), 64'(rf_wdata_o), 64'(vecs[i].rd_wdata));
            end
            if (vecs[i].exp_csr_we) begin
                check($sformatf("v%0d_csr_addr", i), 64'(csr_waddr_o), 64'(vecs[i].csr_addr));
                check($sformatf("v%0d_csr_data", i), 64'(csr_wdata_o), 64'(vecs[i].csr_wdata));
            end
            @(negedge clk_i);
            idle_inputs();
            #1;
            check($sformatf("v%0d_instret", i), instret_o, vecs[i].exp_instret);
        end

        run_trap(32'h0000_0100, 32'd2,         32'h8000_0000, 32'h8000_0000, 64'd4);
        run_trap(32'h0000_0200, 32'h8000_0007, 32'h8000_0001, 32'h8000_001C, 64'd4);
        run_trap(32'h0000_0300, 32'd2,         32'h8000_0001, 32'h8000_0000, 64'd4);
        run_trap(32'h0000_0400, 32'h8000_0005, 32'h0000_1003, 32'h0000_1000, 64'd4);
        run_trap(32'h0000_0500, 32'hBFFF_FFFF, 32'h0000_0101, 32'h0000_00FC, 64'd4);

        // instret wrap from all-ones
        @(negedge clk_i);
        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instret_q;
        @(negedge clk_i);
        #1;
        check("wrap_preload", instret_o, 64'hFFFF_FFFF_FFFF_FFFF);
        wb_q_valid = 1'b1;
        wb_q_rd_addr = 5'd1;
        wb_q_is_rd_write = 1'b1;
        @(negedge clk_i);
        idle_inputs();
        #1;
        check("wrap_instret", instret_o, 64'd0);

        // Reset while writing mcause: back to IDLE, no redirect ever appears
        @(negedge clk_i);
        wb_q_valid       = 1'b1;
        wb_q_trap_valid  = 1'b1;
        wb_q_trap_pc     = 32'h600;
        wb_q_trap_mcause = 32'd11;
        mtvec_i          = 32'h4000;
        @(negedge clk_i);
        idle_inputs();
        @(negedge clk_i);
        #1;
        check("rstmid_in_cause", 64'(csr_waddr_o), 64'h342);
        rst_i = 1'b1;
        #1;
        check("rstmid_csr_we", 64'(csr_we_o), 64'd0);
        check("rstmid_stall", 64'(mem_wb_stall_o), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("rstmid_redirect_c%0d", c), 64'(redirect_valid_o), 64'd0);
            check($sformatf("rstmid_stall_c%0d", c), 64'(mem_wb_stall_o), 64'd0);
            check($sformatf("rstmid_flush_c%0d", c), 64'(mem_wb_flush_o), 64'd0);
            check($sformatf("rstmid_csr_we_c%0d", c), 64'(csr_we_o), 64'd0);
            @(negedge clk_i);
        end
        check("rstmid_instret", instret_o, 64'd0);

        // Normal retire resumes after the aborted trap
        wb_q_valid = 1'b1;
        wb_q_rd_addr = 5'd4;
        wb_q_rd_wdata = 32'hCAFE_F00D;
        wb_q_is_rd_write = 1'b1;
        #1;
        check("resume_rf_we", 64'(rf_we_o), 64'd1);
        check("resume_rf_data", 64'(rf_wdata_o), 64'hCAFE_F00D);
        @(negedge clk_i);
        idle_inputs();
        #1;
        check("resume_instret", instret_o, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
